// File: rtl/stream_mux.sv
// N-channel valid/ready stream multiplexer with fixed-select or round-robin
// arbitration into a single registered output stage.
module stream_mux #(
   parameter int N_CH  = 4,
   parameter int WIDTH = 8,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_CH*WIDTH-1:0]   in_data,
   input  logic [N_CH-1:0]         in_valid,
   output logic [N_CH-1:0]         in_ready,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    mode,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_ch,
   output logic                    out_valid,
   input  logic                    out_ready
);

   logic             rst_done;
   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] rr_grant;
   logic             rr_found;
   logic [SEL_W-1:0] grant;
   logic             grant_ok;
   logic             load_en;
   logic             xfer;
   logic [WIDTH-1:0] grant_data;

   assign load_en = !out_valid || out_ready;

   // Rotating priority search starting at ptr, wrapping past N_CH-1 to 0.
   always_comb begin
      rr_found = 1'b0;
      rr_grant = '0;
      for (int k = 0; k < N_CH; k++) begin
         for (int i = 0; i < N_CH; i++) begin
            if (!rr_found && in_valid[i] &&
                ((int'(ptr) + k == i) || (int'(ptr) + k - N_CH == i))) begin
               rr_found = 1'b1;
               rr_grant = SEL_W'(i);
            end
         end
      end
   end

   always_comb begin
      if (mode) begin
         grant    = rr_grant;
         grant_ok = rr_found;
      end else begin
         grant    = sel;
         grant_ok = (int'(sel) < N_CH);
      end
   end

   // rst_done keeps every ready low until the first edge after reset release.
   always_comb begin
      in_ready   = '0;
      grant_data = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (int'(grant) == i) begin
            in_ready[i] = rst_done && grant_ok && load_en;
            grant_data  = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign xfer = |(in_ready & in_valid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_done  <= 1'b0;
         ptr       <= '0;
         out_data  <= '0;
         out_ch    <= '0;
         out_valid <= 1'b0;
      end else begin
         rst_done <= 1'b1;
         if (xfer) begin
            out_data  <= grant_data;
            out_ch    <= grant;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (mode && xfer) begin
            ptr <= (int'(grant) == N_CH - 1) ? '0 : grant + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_stream_mux.sv
// Directed bench for stream_mux: vector table from reset plus hand sequences
// for stall, asynchronous reset, round-robin throughput and a 3-channel build.
module tb_stream_mux;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [1:0]  sel;
   logic        mode;
   logic [7:0]  out_data;
   logic [1:0]  out_ch;
   logic        out_valid;
   logic        out_ready;

   logic [23:0] in_data3;
   logic [2:0]  in_valid3;
   logic [2:0]  in_ready3;
   logic [1:0]  sel3;
   logic        mode3;
   logic [7:0]  out_data3;
   logic [1:0]  out_ch3;
   logic        out_valid3;
   logic        out_ready3;

   int total = 0;
   int bad   = 0;

   logic [7:0] ch_data [4];

   typedef struct {
      logic       m;
      logic [1:0] s;
      logic [3:0] v;
      logic       ordy;
      logic [3:0] exp_rdy;
      logic       exp_ov;
      logic [7:0] exp_od;
      logic [1:0] exp_ch;
   } vec_t;

   vec_t vecs [13];

   always #5 clk = ~clk;

   stream_mux #(.N_CH(4), .WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sel       (sel),
      .mode      (mode),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   stream_mux #(.N_CH(3), .WIDTH(8)) dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data3),
      .in_valid  (in_valid3),
      .in_ready  (in_ready3),
      .sel       (sel3),
      .mode      (mode3),
      .out_data  (out_data3),
      .out_ch    (out_ch3),
      .out_valid (out_valid3),
      .out_ready (out_ready3)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string name, input logic ov, input logic [7:0] od,
                          input logic [1:0] och);
      chk({name, ".out_valid"}, 64'(out_valid), 64'(ov));
      chk({name, ".out_data"},  64'(out_data),  64'(od));
      chk({name, ".out_ch"},    64'(out_ch),    64'(och));
   endtask

   initial begin
      ch_data[0] = 8'h11;
      ch_data[1] = 8'h22;
      ch_data[2] = 8'hA5;
      ch_data[3] = 8'h44;
      in_data  = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};
      in_data3 = {8'h33, 8'h22, 8'h11};

      //          mode  sel    valid    ordy  rdy      ov    od     ch
      vecs[0]  = '{1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
      vecs[1]  = '{1'b0, 2'd1, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2};
      vecs[2]  = '{1'b0, 2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
      vecs[3]  = '{1'b0, 2'd1, 4'b0000, 1'b1, 4'b0010, 1'b0, 8'h22, 2'd1};
      vecs[4]  = '{1'b0, 2'd3, 4'b0000, 1'b0, 4'b1000, 1'b0, 8'h22, 2'd1};
      vecs[5]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
      vecs[6]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
      vecs[7]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
      vecs[8]  = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd0};
      vecs[9]  = '{1'b1, 2'd0, 4'b0110, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
      vecs[10] = '{1'b0, 2'd0, 4'b0110, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1};
      vecs[11] = '{1'b1, 2'd0, 4'b0110, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
      vecs[12] = '{1'b1, 2'd0, 4'b0011, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};

      rst_n      = 1'b0;
      mode       = 1'b0;
      sel        = 2'd0;
      in_valid   = 4'b0000;
      out_ready  = 1'b0;
      mode3      = 1'b0;
      sel3       = 2'd3;
      in_valid3  = 3'b111;
      out_ready3 = 1'b1;

      #2;
      chk("reset.in_ready", 64'(in_ready), 64'h0);
      chk_out("reset", 1'b0, 8'h00, 2'd0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("release.in_ready_before_edge", 64'(in_ready), 64'h0);
      @(posedge clk);
      #1;
      chk("release.in_ready_after_edge", 64'(in_ready), 64'b0001);

      for (int i = 0; i < 13; i++) begin
         mode      = vecs[i].m;
         sel       = vecs[i].s;
         in_valid  = vecs[i].v;
         out_ready = vecs[i].ordy;
         #1;
         chk($sformatf("vec%0d.in_ready", i), 64'(in_ready), 64'(vecs[i].exp_rdy));
         @(posedge clk);
         #1;
         chk_out($sformatf("vec%0d", i), vecs[i].exp_ov, vecs[i].exp_od, vecs[i].exp_ch);
      end

      // Downstream stall: held word (ch0, 8'h11) must not move.
      mode      = 1'b1;
      in_valid  = 4'b1111;
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("stall%0d.in_ready", c), 64'(in_ready), 64'h0);
         @(posedge clk);
         #1;
         chk_out($sformatf("stall%0d", c), 1'b1, 8'h11, 2'd0);
      end

      // Asynchronous reset between edges while a word is held.
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk_out("async_rst", 1'b0, 8'h00, 2'd0);
      chk("async_rst.in_ready", 64'(in_ready), 64'h0);
      @(negedge clk);
      out_ready = 1'b1;
      rst_n     = 1'b1;
      #1;
      chk("rr_release.in_ready", 64'(in_ready), 64'h0);
      @(posedge clk);
      #1;
      chk("rr_first.in_ready", 64'(in_ready), 64'b0001);
      chk("rr_first.out_valid", 64'(out_valid), 64'h0);

      // Full round-robin throughput; first grant proves ptr was cleared.
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         chk_out($sformatf("rr%0d", k), 1'b1, ch_data[k % 4], 2'(k % 4));
      end

      // Three-channel build: sel=3 is out of range, never ready, never loads.
      chk("n3.sel3.in_ready", 64'(in_ready3), 64'h0);
      chk("n3.sel3.out_valid", 64'(out_valid3), 64'h0);
      sel3 = 2'd2;
      #1;
      chk("n3.sel2.in_ready", 64'(in_ready3), 64'b100);
      @(posedge clk);
      #1;
      chk("n3.sel2.out_valid", 64'(out_valid3), 64'h1);
      chk("n3.sel2.out_data", 64'(out_data3), 64'h33);
      chk("n3.sel2.out_ch", 64'(out_ch3), 64'h2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
